// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared definitions for the processor-facing memory responder: bus widths,
//   the wait-state ceiling, the responder state encoding and a helper that
//   computes the wait-counter preload.
package mem_responder_pkg;

  localparam int ADDR_W          = 8;
  localparam int DATA_W          = 8;
  localparam int WAIT_CNT_W      = 3;
  localparam int MAX_WAIT_STATES = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } MemState;

  // The counter is loaded on entry to WAIT and WAIT is left when it reads zero,
  // so a preload of N-1 yields exactly N WAIT cycles. Only meaningful for N>0.
  function automatic logic [WAIT_CNT_W-1:0] waitLoadValue(input int waitStates);
    return WAIT_CNT_W'(waitStates - 1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array
//   256 x 8 single-port synchronous RAM. One address per cycle; when readEn is
//   high the read register captures either the stored byte or, on a write,
//   the byte being written (write-through). Reset clears only the read
//   register, never the storage.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset (read register only)
//   addr       byte address
//   writeEn    store writeData at addr on this edge
//   writeData  byte to store
//   readEn     update readData on this edge
//   readData   registered read data
module mem_array
  import mem_responder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              writeEn,
  input  logic [DATA_W-1:0] writeData,
  input  logic              readEn,
  output logic [DATA_W-1:0] readData
);

  logic [DATA_W-1:0] storage [0:(1<<ADDR_W)-1];

  // Storage is deliberately left out of reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (writeEn) begin
      storage[addr] <= writeData;
    end
  end

  // Read register only moves when an access completes; writes pass their
  // data straight through so the processor sees what it just stored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readData <= '0;
    end else if (readEn) begin
      readData <= writeEn ? writeData : storage[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Processor memory responder with optional wait states, plus a byte-stream
//   loader that fills the same 256 x 8 array through an auto-incrementing
//   pointer. The processor always wins the single RAM port over the loader.
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   memAddr       processor byte address
//   memStrobe     processor access request
//   memWrite      1 = write, 0 = read (qualifies memStrobe)
//   memDataWrite  processor write data
//   memDataRead   registered read data
//   memReady      one-cycle pulse marking a completed access
//   loadRestart   pulse that returns the load pointer to 0
//   loadValid     loader byte available
//   loadData      loader byte
//   loadReady     loader byte accepted on this edge when high with loadValid
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WAIT_STATES = 0
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic              memStrobe,
  input  logic              memWrite,
  input  logic [DATA_W-1:0] memDataWrite,
  output logic [DATA_W-1:0] memDataRead,
  output logic              memReady,
  input  logic              loadRestart,
  input  logic              loadValid,
  input  logic [DATA_W-1:0] loadData,
  output logic              loadReady
);

  // Out-of-range settings are clamped to the counter's capacity.
  localparam int   EFFECTIVE_WAIT = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES
                                                                     : WAIT_STATES;
  localparam logic ZERO_WAIT      = (EFFECTIVE_WAIT == 0);

  MemState               state;
  logic [WAIT_CNT_W-1:0] waitCnt;
  logic [ADDR_W-1:0]     latAddr;
  logic                  latWrite;
  logic [DATA_W-1:0]     latData;
  logic [ADDR_W-1:0]     loadPtr;

  logic                  startDirect;
  logic                  finishWait;
  logic                  accessNow;
  logic                  loadAccept;
  logic [ADDR_W-1:0]     accAddr;
  logic                  accWrite;
  logic [DATA_W-1:0]     accData;
  logic                  ramWe;
  logic [ADDR_W-1:0]     ramAddr;
  logic [DATA_W-1:0]     ramWdata;

  // The access is performed on the edge that enters ACCESS, so memReady and
  // the read data appear together during the ACCESS cycle. With no wait
  // states that edge is the strobe edge itself, so the live bus is used
  // because the latches are only being loaded on that same edge.
  // Everything that touches the array is gated by reset so an edge seen while
  // reset is held cannot write.
  always_comb begin
    startDirect = (state == IDLE) && memStrobe && ZERO_WAIT;
    finishWait  = (state == WAIT) && (waitCnt == '0);
    accessNow   = !reset && (startDirect || finishWait);
    loadReady   = !reset && (state == IDLE) && !memStrobe;
    loadAccept  = loadValid && loadReady;

    accAddr  = latAddr;
    accWrite = latWrite;
    accData  = latData;
    if (startDirect) begin
      accAddr  = memAddr;
      accWrite = memWrite;
      accData  = memDataWrite;
    end

    // Processor and loader never need the port on the same edge: the loader
    // is only ready in IDLE without a strobe, the processor only accesses
    // from a strobe in IDLE or from WAIT.
    ramAddr  = accessNow ? accAddr : loadPtr;
    ramWdata = accessNow ? accData : loadData;
    ramWe    = (accessNow && accWrite) || loadAccept;
  end

  // Responder FSM, wait counter, request latches, ready pulse and load pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      waitCnt  <= '0;
      latAddr  <= '0;
      latWrite <= 1'b0;
      latData  <= '0;
      memReady <= 1'b0;
      loadPtr  <= '0;
    end else begin
      memReady <= accessNow;

      if (loadRestart) begin
        loadPtr <= '0;
      end else if (loadAccept) begin
        loadPtr <= loadPtr + 1'b1;
      end

      case (state)
        IDLE: begin
          if (memStrobe) begin
            latAddr  <= memAddr;
            latWrite <= memWrite;
            latData  <= memDataWrite;
            if (ZERO_WAIT) begin
              state <= ACCESS;
            end else begin
              state   <= WAIT;
              waitCnt <= waitLoadValue(EFFECTIVE_WAIT);
            end
          end
        end
        WAIT: begin
          if (waitCnt == '0) begin
            state <= ACCESS;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        ACCESS: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  mem_array u_memArray (
    .clk       (clk),
    .reset     (reset),
    .addr      (ramAddr),
    .writeEn   (ramWe),
    .writeData (ramWdata),
    .readEn    (accessNow),
    .readData  (memDataRead)
  );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Drives two responders (no wait states and three wait states) with
//   directed processor and loader traffic. A reference memory image tracks
//   array contents; expected read data is queued when an access is issued
//   and compared when memReady is seen.
module tb_mem_responder;

  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic       clk = 1'b0;
  logic       reset        [2];
  logic [7:0] memAddr      [2];
  logic       memStrobe    [2];
  logic       memWrite     [2];
  logic [7:0] memDataWrite [2];
  logic [7:0] memDataRead  [2];
  logic       memReady     [2];
  logic       loadRestart  [2];
  logic       loadValid    [2];
  logic [7:0] loadData     [2];
  logic       loadReady    [2];

  logic [7:0] refMem [2][256];
  logic [7:0] refPtr [2];
  logic [7:0] refRd  [2];
  logic [7:0] expQ   [$];

  int checks = 0;
  int errors = 0;

  mem_responder #(.WAIT_STATES(WS0)) dut0 (
    .clk(clk), .reset(reset[0]), .memAddr(memAddr[0]), .memStrobe(memStrobe[0]),
    .memWrite(memWrite[0]), .memDataWrite(memDataWrite[0]), .memDataRead(memDataRead[0]),
    .memReady(memReady[0]), .loadRestart(loadRestart[0]), .loadValid(loadValid[0]),
    .loadData(loadData[0]), .loadReady(loadReady[0])
  );

  mem_responder #(.WAIT_STATES(WS1)) dut1 (
    .clk(clk), .reset(reset[1]), .memAddr(memAddr[1]), .memStrobe(memStrobe[1]),
    .memWrite(memWrite[1]), .memDataWrite(memDataWrite[1]), .memDataRead(memDataRead[1]),
    .memReady(memReady[1]), .loadRestart(loadRestart[1]), .loadValid(loadValid[1]),
    .loadData(loadData[1]), .loadReady(loadReady[1])
  );

  // Free-running clock; inputs change and outputs are sampled on falling edges.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Processor access; optionally fires a stray write strobe during WAIT that
  // must be ignored. Enters and leaves on a falling edge.
  task automatic applyStimulus(input int d, input logic wr, input logic [7:0] addr,
                               input logic [7:0] wdata, input logic ghost);
    int ws;
    logic [7:0] held;
    logic [7:0] exp;
    ws = (d == 0) ? WS0 : WS1;
    memStrobe[d] = 1'b1; memWrite[d] = wr; memAddr[d] = addr; memDataWrite[d] = wdata;
    #1 checkOutput("loadReadyDuringStrobe", {7'd0, loadReady[d]}, 8'd0);
    expQ.push_back(wr ? wdata : refMem[d][addr]);
    if (wr) refMem[d][addr] = wdata;
    held = refRd[d];
    @(negedge clk);
    memStrobe[d] = 1'b0; memWrite[d] = 1'b0;
    for (int c = 1; c <= ws + 1; c++) begin
      if (c == ws + 1) begin
        checkOutput("memReadyPulse", {7'd0, memReady[d]}, 8'd1);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $error("[TB] FAIL scoreboardEmpty: observed 0 entries expected 1");
        end else begin
          exp = expQ.pop_front();
          checkOutput("memDataRead", memDataRead[d], exp);
          refRd[d] = exp;
        end
      end else begin
        checkOutput("memReadyEarly", {7'd0, memReady[d]}, 8'd0);
        checkOutput("memDataReadHold", memDataRead[d], held);
      end
      if (ghost && c == 2) begin
        memStrobe[d] = 1'b1; memWrite[d] = 1'b1;
        memAddr[d] = addr + 8'd1; memDataWrite[d] = 8'hFF;
      end
      @(negedge clk);
      memStrobe[d] = 1'b0; memWrite[d] = 1'b0;
    end
    checkOutput("memReadyOneCycle", {7'd0, memReady[d]}, 8'd0);
    checkOutput("memDataReadAfter", memDataRead[d], refRd[d]);
  endtask

  // One loader beat, optionally with loadRestart in the same cycle.
  task automatic loadByte(input int d, input logic [7:0] data, input logic restart);
    loadValid[d] = 1'b1; loadData[d] = data; loadRestart[d] = restart;
    #1 checkOutput("loadReadyIdle", {7'd0, loadReady[d]}, 8'd1);
    refMem[d][refPtr[d]] = data;
    refPtr[d] = restart ? 8'd0 : refPtr[d] + 8'd1;
    @(negedge clk);
    loadValid[d] = 1'b0; loadRestart[d] = 1'b0;
    checkOutput("memReadyLoader", {7'd0, memReady[d]}, 8'd0);
    checkOutput("memDataReadLoader", memDataRead[d], refRd[d]);
  endtask

  task automatic restartLoader(input int d);
    loadRestart[d] = 1'b1;
    @(negedge clk);
    loadRestart[d] = 1'b0;
    refPtr[d] = 8'd0;
  endtask

  function automatic logic [7:0] fillValue(input int a);
    logic [7:0] a8;
    a8 = 8'(a);
    if (a == 'h10) return 8'hA5;
    if (a == 'h40) return 8'h77;
    return a8 ^ 8'h5C;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; memAddr[d] = '0; memStrobe[d] = 1'b0; memWrite[d] = 1'b0;
      memDataWrite[d] = '0; loadRestart[d] = 1'b0; loadValid[d] = 1'b0; loadData[d] = '0;
      refPtr[d] = '0; refRd[d] = '0;
    end

    // Reset state of both instances.
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput("resetDataRead", memDataRead[d], 8'h00);
      checkOutput("resetReady", {7'd0, memReady[d]}, 8'd0);
      checkOutput("resetLoadReady", {7'd0, loadReady[d]}, 8'd0);
    end
    reset[0] = 1'b0; reset[1] = 1'b0;
    @(negedge clk);

    $display("[TB] zero wait states: loader fill and reads");
    restartLoader(0);
    loadByte(0, 8'h01, 1'b0);
    loadByte(0, 8'h02, 1'b0);
    loadByte(0, 8'h03, 1'b0);
    applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(0, 1'b0, 8'h01, 8'h00, 1'b0);
    applyStimulus(0, 1'b0, 8'h02, 8'h00, 1'b0);
    for (int a = 3; a < 256; a++) loadByte(0, fillValue(a), 1'b0);
    loadByte(0, 8'hEE, 1'b0);
    applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(0, 1'b0, 8'h10, 8'h00, 1'b0);
    checkOutput("readA5", memDataRead[0], 8'hA5);
    applyStimulus(0, 1'b0, 8'hFF, 8'h00, 1'b0);

    $display("[TB] zero wait states: write-through and read back");
    applyStimulus(0, 1'b1, 8'h30, 8'h5A, 1'b0);
    applyStimulus(0, 1'b0, 8'h30, 8'h00, 1'b0);

    $display("[TB] zero wait states: restart with simultaneous accept");
    loadByte(0, 8'h99, 1'b1);
    loadByte(0, 8'h42, 1'b0);
    applyStimulus(0, 1'b0, 8'h01, 8'h00, 1'b0);
    applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b0);

    $display("[TB] zero wait states: processor priority over loader");
    memStrobe[0] = 1'b1; memWrite[0] = 1'b0; memAddr[0] = 8'h30;
    loadValid[0] = 1'b1; loadData[0] = 8'h33;
    #1 checkOutput("loadReadyPriority", {7'd0, loadReady[0]}, 8'd0);
    @(negedge clk);
    memStrobe[0] = 1'b0;
    checkOutput("priorityReady", {7'd0, memReady[0]}, 8'd1);
    checkOutput("priorityData", memDataRead[0], refMem[0][8'h30]);
    refRd[0] = refMem[0][8'h30];
    checkOutput("loadReadyInAccess", {7'd0, loadReady[0]}, 8'd0);
    @(negedge clk);
    checkOutput("loadReadyResume", {7'd0, loadReady[0]}, 8'd1);
    checkOutput("priorityReadyDrop", {7'd0, memReady[0]}, 8'd0);
    refMem[0][refPtr[0]] = 8'h33;
    refPtr[0] = refPtr[0] + 8'd1;
    @(negedge clk);
    loadValid[0] = 1'b0;
    applyStimulus(0, 1'b0, 8'h01, 8'h00, 1'b0);

    $display("[TB] three wait states: fill, delayed read, ignored strobe");
    restartLoader(1);
    for (int a = 0; a <= 'h40; a++) loadByte(1, 8'(a) ^ 8'hC3, 1'b0);
    applyStimulus(1, 1'b0, 8'h20, 8'h00, 1'b1);
    applyStimulus(1, 1'b0, 8'h21, 8'h00, 1'b0);
    applyStimulus(1, 1'b1, 8'h30, 8'h5A, 1'b0);
    applyStimulus(1, 1'b0, 8'h30, 8'h00, 1'b0);

    $display("[TB] three wait states: reset during WAIT of a write");
    memStrobe[1] = 1'b1; memWrite[1] = 1'b1; memAddr[1] = 8'h40; memDataWrite[1] = 8'h11;
    @(negedge clk);
    memStrobe[1] = 1'b0; memWrite[1] = 1'b0;
    checkOutput("abortReadyBefore", {7'd0, memReady[1]}, 8'd0);
    @(negedge clk);
    reset[1] = 1'b1;
    #1;
    checkOutput("abortDataRead", memDataRead[1], 8'h00);
    checkOutput("abortLoadReady", {7'd0, loadReady[1]}, 8'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("abortReadyHeld", {7'd0, memReady[1]}, 8'd0);
    end
    reset[1] = 1'b0;
    refRd[1] = 8'h00;
    refPtr[1] = 8'h00;
    @(negedge clk);
    checkOutput("abortIdle", {7'd0, loadReady[1]}, 8'd1);
    checkOutput("abortReadyAfter", {7'd0, memReady[1]}, 8'd0);
    checkOutput("abortDataAfter", memDataRead[1], 8'h00);
    applyStimulus(1, 1'b0, 8'h40, 8'h00, 1'b0);
    checkOutput("abortArrayKept", memDataRead[1], 8'h83);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL provide parameter WAIT_STATES, default 0, meaning extra cycles inserted before each processor access completes (legal range 0..7).
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port clk  input  1  system clock, all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port memAddr  input  8  processor byte address.
REQ-006 SHALL have port memStrobe  input  1  processor access request, sampled at the rising edge.
REQ-007 SHALL have port memWrite  input  1  qualifies memStrobe: 1 = write, 0 = read.
REQ-008 SHALL have port memDataWrite  input  8  processor write data.
REQ-009 SHALL have port memDataRead  output  8  registered read data.
REQ-010 SHALL have port memReady  output  1  one-cycle pulse marking completion of an access.
REQ-011 SHALL have port loadRestart  input  1  pulse that sets the load pointer to 0.
REQ-012 SHALL have port loadValid  input  1  loader byte available.
REQ-013 SHALL have port loadData  input  8  loader byte.
REQ-014 SHALL have port loadReady  output  1  loader byte accepted this edge when high together with loadValid.

Function
REQ-015 SHALL store 256 x 8 bits, addressed directly by memAddr, with no address wrap logic needed.
REQ-016 SHALL implement the states IDLE, WAIT and ACCESS.
REQ-017 In IDLE, when memStrobe=1, SHALL latch memAddr, memWrite and memDataWrite, then go to ACCESS if WAIT_STATES=0, else go to WAIT.
REQ-018 In WAIT, SHALL count WAIT_STATES cycles with a 3-bit down-counter, then go to ACCESS.
REQ-019 In ACCESS, SHALL perform the latched read or write, drive memReady=1 for exactly that cycle, and return to IDLE on the next edge.
REQ-020 For a read, memDataRead SHALL be updated at the ACCESS edge. With WAIT_STATES=0, data SHALL be valid the cycle after the strobe edge, which matches the strobe-then-read fetch timing the processor already uses.
REQ-021 For a write, the array SHALL be written at the ACCESS edge, and memDataRead SHALL take the written value (write-through).
REQ-022 SHALL ignore memStrobe while in WAIT or ACCESS: no queueing, no latch update.
REQ-023 SHALL hold memDataRead unchanged whenever no access completes.
REQ-024 SHALL drive loadReady = (state==IDLE) & ~memStrobe, so the processor has priority over the loader.
REQ-025 On loadValid & loadReady, SHALL write loadData at the load pointer and increment the pointer modulo 256 (255 wraps to 0).
REQ-026 loadRestart SHALL take priority over a simultaneous load accept: the pointer becomes 0, and the accepted byte is written at the old pointer.
REQ-027 SHALL cause no change to memReady or memDataRead from loader writes.
REQ-028 SHALL return the new byte when a processor read targets an address written by the loader in an earlier cycle.

Reset
REQ-029 Asserting reset SHALL immediately force state=IDLE, wait counter=0, load pointer=0, memDataRead=8'h00, memReady=0.
REQ-030 Reset SHALL not clear array contents; initial contents come from elaboration-time initialisation.
REQ-031 An access in progress when reset asserts SHALL be abandoned: no array write and no memReady pulse.
REQ-032 loadReady SHALL be 0 while reset is asserted.

Structure
REQ-033 State encoding and the WAIT_STATES maximum (7) SHALL live in the shared package.
REQ-034 The storage SHALL be a sub-module mem_array: 256x8 single-port synchronous RAM with write enable, one read per cycle, and write-through read data.

Verification
REQ-035 WAIT_STATES=0, mem[0x10]=0xA5, strobe read 0x10 -> next cycle memDataRead=0xA5 and memReady=1 for exactly 1 cycle.
REQ-036 WAIT_STATES=3, strobe read 0x20 -> memReady rises on the 4th cycle after the strobe edge; a second strobe during WAIT is ignored.
REQ-037 Write 0x5A to 0x30, then read 0x30 -> the write cycle gives memDataRead=0x5A, and the read returns 0x5A.
REQ-038 loadRestart, then load 0x01,0x02,0x03 -> mem[0..2]=01,02,03; after 256 accepts the pointer wraps and mem[0] is overwritten.
REQ-039 loadValid=1 together with memStrobe in IDLE -> loadReady=0, the processor access completes, and the load byte is accepted on the first IDLE cycle without a strobe.
REQ-040 Reset asserted during WAIT of a write to 0x40 -> memReady stays 0, mem[0x40] is unchanged, memDataRead=0x00, state=IDLE.
